// File: rtl/dds_param_loader.sv
// dds_param_loader: framed byte-command parser that stages DDS parameters in shadow registers and applies them together on COMMIT
// Ports: clk, rst_n (async active-low) | rx_data[7:0], rx_valid: received byte + 1-cycle strobe
//        mode[2:0], fc[23:0], fs[23:0], ma[3:0], fd[15:0]: DDS control outputs | ack, err: 1-cycle frame status pulses
module dds_param_loader #(
  parameter int          TIMEOUT_CYC = 100_000,
  parameter logic [23:0] FC_RST      = 24'd1_000_000,
  parameter logic [23:0] FS_RST      = 24'd1_000,
  parameter logic [3:0]  MA_RST      = 4'd5,
  parameter logic [15:0] FD_RST      = 16'd1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [2:0]  mode,
  output logic [23:0] fc,
  output logic [23:0] fs,
  output logic [3:0]  ma,
  output logic [15:0] fd,
  output logic        ack,
  output logic        err
);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_D2, S_D1, S_D0, S_CHK} state_t;
  state_t r_state, w_next;
  logic [7:0] r_addr, r_d2, r_d1, r_d0, r_xor;
  logic [GW-1:0] r_gap;
  logic [2:0] r_sh_mode;
  logic [23:0] r_sh_fc, r_sh_fs;
  logic [3:0] r_sh_ma;
  logic [15:0] r_sh_fd;
  logic w_legal, w_ok, w_bad, w_tmo;
  // mode only accepts the five defined DDS modes; high D0 bits are ignored
  assign w_legal = (r_addr == 8'h00) ? (r_d0[2:0] <= 3'd4)
                 : ((r_addr >= 8'h01 && r_addr <= 8'h04) || r_addr == 8'h0F);
  always_comb begin
    w_next = r_state;
    w_ok   = 1'b0;
    w_bad  = 1'b0;
    w_tmo  = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE:  w_next = (rx_data == 8'hA5) ? S_ADDR : S_IDLE;
        S_ADDR:  w_next = S_D2;
        S_D2:    w_next = S_D1;
        S_D1:    w_next = S_D0;
        S_D0:    w_next = S_CHK;
        S_CHK: begin
          w_next = S_IDLE;
          w_ok   = (rx_data == r_xor) && w_legal;
          w_bad  = !((rx_data == r_xor) && w_legal);
        end
        default: w_next = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_gap == GAP_MAX) begin
      // a byte in the timeout cycle wins, so only a silent gap aborts the frame
      w_next = S_IDLE;
      w_tmo  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap     <= '0;
      r_addr    <= '0;
      r_d2      <= '0;
      r_d1      <= '0;
      r_d0      <= '0;
      r_xor     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      r_sh_mode <= 3'd0;
      r_sh_fc   <= FC_RST;
      r_sh_fs   <= FS_RST;
      r_sh_ma   <= MA_RST;
      r_sh_fd   <= FD_RST;
      mode      <= 3'd0;
      fc        <= FC_RST;
      fs        <= FS_RST;
      ma        <= MA_RST;
      fd        <= FD_RST;
    end else begin
      r_gap <= (rx_valid || r_state == S_IDLE || w_tmo) ? '0 : r_gap + 1'b1;
      ack   <= w_ok;
      err   <= w_bad || w_tmo;
      if (rx_valid) begin
        case (r_state)
          S_ADDR: begin
            r_addr <= rx_data;
            r_xor  <= rx_data;
          end
          S_D2: begin
            r_d2  <= rx_data;
            r_xor <= r_xor ^ rx_data;
          end
          S_D1: begin
            r_d1  <= rx_data;
            r_xor <= r_xor ^ rx_data;
          end
          S_D0: begin
            r_d0  <= rx_data;
            r_xor <= r_xor ^ rx_data;
          end
          default: ;
        endcase
      end
      if (w_ok) begin
        case (r_addr)
          8'h00: r_sh_mode <= r_d0[2:0];
          8'h01: r_sh_fc   <= {r_d2, r_d1, r_d0};
          8'h02: r_sh_fs   <= {r_d2, r_d1, r_d0};
          8'h03: r_sh_ma   <= r_d0[3:0];
          8'h04: r_sh_fd   <= {r_d1, r_d0};
          8'h0F: begin
            mode <= r_sh_mode;
            fc   <= r_sh_fc;
            fs   <= r_sh_fs;
            ma   <= r_sh_ma;
            fd   <= r_sh_fd;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dds_param_loader.sv
// tb_dds_param_loader: directed and randomized frame checks of dds_param_loader against a shadow/commit reference model
module tb_dds_param_loader;
  localparam int TMO = 40;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] mode;
  logic [23:0] fc, fs;
  logic [3:0] ma;
  logic [15:0] fd;
  logic ack, err;
  int n_chk = 0, n_err = 0;
  logic [2:0] m_mode, s_mode;
  logic [23:0] m_fc, s_fc, m_fs, s_fs;
  logic [3:0] m_ma, s_ma;
  logic [15:0] m_fd, s_fd;

  dds_param_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mode(mode), .fc(fc), .fs(fs), .ma(ma), .fd(fd), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_mode"}, 32'(mode), 32'(m_mode));
    check({tag, "_fc"}, 32'(fc), 32'(m_fc));
    check({tag, "_fs"}, 32'(fs), 32'(m_fs));
    check({tag, "_ma"}, 32'(ma), 32'(m_ma));
    check({tag, "_fd"}, 32'(fd), 32'(m_fd));
  endtask

  task automatic model_reset();
    m_mode = 3'd0; s_mode = 3'd0;
    m_fc = 24'd1_000_000; s_fc = 24'd1_000_000;
    m_fs = 24'd1_000; s_fs = 24'd1_000;
    m_ma = 4'd5; s_ma = 4'd5;
    m_fd = 16'd1_000; s_fd = 16'd1_000;
  endtask

  // Called at a negedge; bytes go out on consecutive cycles and the status is checked the cycle after CHK.
  task automatic send_frame(input string tag, input logic [7:0] a, d2, d1, d0, chk);
    logic [7:0] f[6];
    bit ok;
    f = '{8'hA5, a, d2, d1, d0, chk};
    for (int i = 0; i < 6; i++) begin
      rx_data = f[i];
      rx_valid = 1'b1;
      @(negedge clk);
      if (i < 5) check({tag, "_quiet"}, {30'd0, ack, err}, 32'd0);
    end
    rx_valid = 1'b0;
    ok = (chk == (a ^ d2 ^ d1 ^ d0)) &&
         ((a >= 8'd1 && a <= 8'd4) || a == 8'h0F || (a == 8'h00 && (d0 % 8) <= 4));
    if (ok) begin
      if (a == 8'h00) s_mode = 3'(d0 % 8);
      if (a == 8'h01) s_fc = d2 * 65536 + d1 * 256 + d0;
      if (a == 8'h02) s_fs = d2 * 65536 + d1 * 256 + d0;
      if (a == 8'h03) s_ma = 4'(d0 % 16);
      if (a == 8'h04) s_fd = d1 * 256 + d0;
      if (a == 8'h0F) begin
        m_mode = s_mode; m_fc = s_fc; m_fs = s_fs; m_ma = s_ma; m_fd = s_fd;
      end
    end
    check({tag, "_ack"}, 32'(ack), 32'(ok));
    check({tag, "_err"}, 32'(err), 32'(!ok));
    check_outs(tag);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] a, d2, d1, d0);
    send_frame(tag, a, d2, d1, d0, a ^ d2 ^ d1 ^ d0);
  endtask

  initial begin
    int errs, acks, first;
    logic [7:0] a, d2, d1, d0, c;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outs("reset");
    check("reset_status", {30'd0, ack, err}, 32'd0);

    send_cmd("fc_stage", 8'h01, 8'h0F, 8'h42, 8'h40);
    send_cmd("commit1", 8'h0F, 8'h00, 8'h00, 8'h00);
    send_cmd("fc_stage2", 8'h01, 8'h65, 8'h43, 8'h21);
    check("fc_held", 32'(fc), 32'd1_000_000);
    send_cmd("commit2", 8'h0F, 8'h00, 8'h00, 8'h00);
    check("fc_applied", 32'(fc), 32'h654321);

    send_cmd("mode2", 8'h00, 8'h00, 8'h00, 8'h02);
    send_cmd("fd5000", 8'h04, 8'h00, 8'h13, 8'h88);
    check("mode_held", 32'(mode), 32'd0);
    send_cmd("commit3", 8'h0F, 8'h00, 8'h00, 8'h00);
    check("mode_fd_together", {13'd0, mode, fd}, {13'd0, 3'd2, 16'd5000});

    send_frame("bad_chk", 8'h03, 8'h00, 8'h00, 8'h07, 8'h05);
    send_frame("mode7", 8'h00, 8'h00, 8'h00, 8'h07, 8'h07);
    send_cmd("bad_addr", 8'h07, 8'h11, 8'h22, 8'h33);
    send_cmd("commit4", 8'h0F, 8'h00, 8'h00, 8'h00);
    check("ma_unchanged", 32'(ma), 32'd5);

    rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h01;
    @(negedge clk);
    rx_valid = 1'b0;
    errs = 0; acks = 0; first = -1;
    for (int cyc = 1; cyc <= TMO + 10; cyc++) begin
      @(negedge clk);
      if (err) begin
        errs++;
        if (first < 0) first = cyc;
      end
      if (ack) acks++;
    end
    check("timeout_err_count", 32'(errs), 32'd1);
    check("timeout_err_cycle", 32'(first), 32'(TMO));
    check("timeout_no_ack", 32'(acks), 32'd0);
    send_cmd("after_timeout", 8'h03, 8'h00, 8'h00, 8'h09);

    send_cmd("a5_as_data", 8'h02, 8'hA5, 8'hA5, 8'hA5);
    send_cmd("commit5", 8'h0F, 8'hA5, 8'h00, 8'h00);
    check("fs_a5", 32'(fs), 32'hA5A5A5);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 8);
      a = (r < 5) ? 8'(r) : (r < 7) ? 8'h0F : (r == 7) ? 8'($urandom_range(5, 14)) : 8'($urandom_range(16, 255));
      d2 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      d0 = (a == 8'h00) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      c = a ^ d2 ^ d1 ^ d0;
      if ($urandom_range(0, 5) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
      send_frame("rand", a, d2, d1, d0, c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    send_cmd("rand_commit", 8'h0F, 8'h00, 8'h00, 8'h00);

    send_cmd("pre_rst_fc", 8'h01, 8'h00, 8'h00, 8'h01);
    send_cmd("pre_rst_commit", 8'h0F, 8'h00, 8'h00, 8'h00);
    rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h01;
    @(negedge clk);
    rx_data = 8'h12;
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_rst");
    check("post_rst_status", {30'd0, ack, err}, 32'd0);
    send_cmd("fresh_fc", 8'h01, 8'h12, 8'h34, 8'h56);
    send_cmd("fresh_commit", 8'h0F, 8'h00, 8'h00, 8'h00);
    check("fresh_fc_val", 32'(fc), 32'h123456);
    acks = 0; errs = 0;
    rx_valid = 1'b1;
    rx_data = 8'h11;
    @(negedge clk);
    rx_data = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (TMO + 5) begin
      @(negedge clk);
      if (ack) acks++;
      if (err) errs++;
    end
    check("stray_status", 32'(acks + errs), 32'd0);
    check_outs("stray");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
